bram_port_arbiter: RTL and testbench
====================================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter CORE, default 0, core index used in scan reports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, BRAM word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, BRAM word address width.
REQ-004 SHALL have parameter NUM_REQ, default 2, number of requesters (2..8).
REQ-005 SHALL have parameters SCAN_CYCLES_MIN, default 0, and SCAN_CYCLES_MAX, default 1000, which bound the scan-report window.
REQ-006 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port req_valid, input, NUM_REQ, per-requester request valid.
REQ-009 SHALL have port req_write, input, NUM_REQ, per-requester write (1) or read (0) select.
REQ-010 SHALL have port req_addr, input, NUM_REQ*ADDR_WIDTH, packed addresses, requester i at slice i.
REQ-011 SHALL have port req_wdata, input, NUM_REQ*DATA_WIDTH, packed write data.
REQ-012 SHALL have port req_ready, output, NUM_REQ, one-hot grant; request i is accepted when req_valid[i] and req_ready[i] are both high.
REQ-013 SHALL have port resp_valid, output, NUM_REQ, one-hot completion pulse.
REQ-014 SHALL have port resp_rdata, output, DATA_WIDTH, read data, valid when resp_valid is high for a read.
REQ-015 SHALL have ports readEnable, writeEnable, address and writeData as outputs, and readData as an input, that connect to one dual_port_BRAM port.
REQ-016 SHALL have port scan, input, 1, which enables the cycle report.

Function
REQ-017 SHALL grant at most one requester per cycle, and only a requester with req_valid high.
REQ-018 SHALL drive readEnable, writeEnable, address and writeData combinationally from the granted request in the grant cycle; all four are 0 when nothing is granted.
REQ-019 SHALL register the granted index and the read/write type at the grant edge.
REQ-020 SHALL pulse resp_valid[granted index] exactly one cycle after the grant, for both reads and writes.
REQ-021 SHALL drive resp_rdata = readData during a read response cycle, and hold resp_rdata at 0 otherwise.
REQ-022 SHALL support back-to-back grants at full throughput: one request issued and one response delivered per cycle.
REQ-023 SHALL be usable by a requester that holds req_valid high across cycles with changing fields; only fields sampled in a grant cycle are issued.
REQ-024 SHALL count cycles with a free-running counter; when scan is high and the count is between SCAN_CYCLES_MIN and SCAN_CYCLES_MAX inclusive, it SHALL $display CORE, the grant vector, address and the resp_valid vector.

Reset
REQ-025 SHALL, while reset is high, drive req_ready=0, resp_valid=0, resp_rdata=0 and all BRAM outputs 0, and set the priority pointer and cycle counter to 0.
REQ-026 SHALL cancel the pending response of a request granted in the cycle reset asserts; no resp_valid pulse follows reset.
REQ-027 SHALL allow a grant in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL, with macro BRAM_ARB_ROUND_ROBIN_EN defined, grant round-robin: search starts at pointer, and pointer becomes (granted index + 1) mod NUM_REQ after each grant.
REQ-029 SHALL, without BRAM_ARB_ROUND_ROBIN_EN, use fixed priority: the lowest index wins and the pointer is unused, held at 0.

Structure
REQ-030 SHALL place shared constants (maximum NUM_REQ, the index width function log2 of NUM_REQ) in a shared package/header used by the arbiter and the bench.
REQ-031 SHALL implement grant selection in a single sub-module, rr_priority_select, with inputs request vector and pointer and output one-hot grant; the top holds the pointer, response pipeline and scan counter.

Verification
REQ-032 SHALL cover single write then read: req 0 writes addr 5 = 0xA5 -> resp_valid=01 next cycle; req 0 reads addr 5 -> resp_valid=01 and resp_rdata=0xA5 one cycle later.
REQ-033 SHALL cover contention with BRAM_ARB_ROUND_ROBIN_EN: both requesters read continuously for 4 cycles -> grants 01,10,01,10 and responses follow one cycle behind each grant.
REQ-034 SHALL cover fixed priority (macro undefined): both requesters valid for 3 cycles -> req_ready=01 every cycle and requester 1 is starved.
REQ-035 SHALL cover pipelining: req 1 writes addr 1 = 11, then req 0 reads addr 1 next cycle -> resp_rdata=11 with resp_valid=01.
REQ-036 SHALL cover reset mid-operation: read granted, reset high the next edge -> no resp_valid pulse, all outputs 0 and pointer 0.
REQ-037 SHALL cover idle: no req_valid -> readEnable=writeEnable=0, req_ready=0, resp_valid=0.

Source files
------------

// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants for the BRAM port arbiter and its bench: requester limits
// and the pointer/index width helper.
package bram_port_arbiter_pkg;

  localparam int unsigned MIN_NUM_REQ = 2;
  localparam int unsigned MAX_NUM_REQ = 8;

  // Width of a requester index; a 2-requester arbiter still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// One-hot grant selection: first requester found when scanning upward from ptr,
// wrapping modulo NUM_REQ. A pointer of 0 gives plain lowest-index priority.
module rr_priority_select
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Arbitrates NUM_REQ requesters onto one BRAM port with a one-cycle response.
// Define BRAM_ARB_ROUND_ROBIN_EN for round-robin grants; fixed priority otherwise.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int          CORE            = 0,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned NUM_REQ         = 2,
  parameter int          SCAN_CYCLES_MIN = 0,
  parameter int          SCAN_CYCLES_MAX = 1000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_rdata,
  output logic                          readEnable,
  output logic                          writeEnable,
  output logic [ADDR_WIDTH-1:0]         address,
  output logic [DATA_WIDTH-1:0]         writeData,
  input  logic [DATA_WIDTH-1:0]         readData,
  input  logic                          scan
);

  localparam int unsigned PTR_W = idx_width(NUM_REQ);
  localparam int unsigned CNT_W = 31;

  if (NUM_REQ < MIN_NUM_REQ || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
    $error("bram_port_arbiter: NUM_REQ out of range");
  end

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               pend_valid_q, pend_valid_d;
  logic [PTR_W-1:0]   pend_idx_q, pend_idx_d;
  logic               pend_read_q, pend_read_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [NUM_REQ-1:0] sel_grant;
  logic [NUM_REQ-1:0] grant_c;
  logic [PTR_W-1:0]   grant_idx_c;
  logic               grant_any_c;
  logic               grant_write_c;

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_select (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (sel_grant)
  );

  // Grant-cycle mux: the granted request drives the BRAM port directly.
  always_comb begin
    grant_c       = reset ? '0 : sel_grant;
    grant_any_c   = |grant_c;
    grant_idx_c   = '0;
    grant_write_c = 1'b0;
    address       = '0;
    writeData     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        grant_idx_c   = PTR_W'(i);
        grant_write_c = req_write[i];
        address       = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        writeData     = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    req_ready   = grant_c;
    readEnable  = grant_any_c & ~grant_write_c;
    writeEnable = grant_any_c & grant_write_c;
  end

  always_comb begin
    pend_valid_d = grant_any_c;
    pend_idx_d   = grant_idx_c;
    pend_read_d  = grant_any_c & ~grant_write_c;
    cycle_d      = cycle_q + CNT_W'(1);
`ifdef BRAM_ARB_ROUND_ROBIN_EN
    ptr_d = ptr_q;
    if (grant_any_c) begin
      ptr_d = (grant_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + PTR_W'(1);
    end
`else
    ptr_d = '0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_idx_q   <= '0;
      pend_read_q  <= 1'b0;
      cycle_q      <= '0;
    end else begin
      ptr_q        <= ptr_d;
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= pend_idx_d;
      pend_read_q  <= pend_read_d;
      cycle_q      <= cycle_d;
    end
  end

  // Response cycle: reset in this cycle suppresses the pulse.
  always_comb begin
    resp_valid = '0;
    resp_rdata = '0;
    if (pend_valid_q && !reset) begin
      resp_valid[pend_idx_q] = 1'b1;
      if (pend_read_q) resp_rdata = readData;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (scan && (int'({1'b0, cycle_q}) >= SCAN_CYCLES_MIN) &&
        (int'({1'b0, cycle_q}) <= SCAN_CYCLES_MAX)) begin
      $display("[core %0d] cycle %0d grant=%b addr=%0h resp_valid=%b",
               CORE, cycle_q, req_ready, address, resp_valid);
    end
  end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized bench for bram_port_arbiter with a BRAM model and a transaction-level
// reference; honours BRAM_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_bram_port_arbiter;
  import bram_port_arbiter_pkg::*;

  localparam int unsigned NUM_REQ  = 2;
  localparam int unsigned DW       = 32;
  localparam int unsigned AW       = 8;
  localparam int unsigned TB_PTR_W = idx_width(NUM_REQ);

  logic                  clock;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [DW-1:0]         resp_rdata;
  logic                  readEnable;
  logic                  writeEnable;
  logic [AW-1:0]         address;
  logic [DW-1:0]         writeData;
  logic [DW-1:0]         readData;
  logic                  scan;

  bram_port_arbiter #(
    .CORE            (0),
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .NUM_REQ         (NUM_REQ),
    .SCAN_CYCLES_MIN (0),
    .SCAN_CYCLES_MAX (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .readEnable  (readEnable),
    .writeEnable (writeEnable),
    .address     (address),
    .writeData   (writeData),
    .readData    (readData),
    .scan        (scan)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single BRAM port: registered read, one-cycle latency.
  logic [DW-1:0] bram [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (writeEnable) bram[address] <= writeData;
    if (readEnable) readData <= bram[address];
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0]       ref_mem [0:(1<<AW)-1];
  int                  ref_ptr = 0;
  logic                pend_v = 1'b0;
  logic [TB_PTR_W-1:0] pend_idx = '0;
  logic                pend_rd = 1'b0;
  logic [DW-1:0]       pend_data = '0;

  logic [NUM_REQ-1:0] obs_ready, obs_rvalid;
  logic [DW-1:0]      obs_rdata;
  logic               obs_re, obs_we;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Applies one cycle of inputs, checks every output against the reference, advances it.
  task automatic run_cycle(input logic rst, input logic [1:0] v, input logic [1:0] w,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int            gi;
    logic [1:0]    eg, erv;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, erd;
    logic          ewr;
    reset     = rst;
    req_valid = v;
    req_write = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    #4;
    gi = -1;
    if (!rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int j;
        j = (ref_ptr + k) % NUM_REQ;
        if (gi < 0 && v[j]) gi = j;
      end
    end
    eg = '0; ea = '0; ed = '0; ewr = 1'b0;
    if (gi >= 0) begin
      eg[gi] = 1'b1;
      ewr    = w[gi];
      ea     = (gi == 1) ? a1 : a0;
      ed     = (gi == 1) ? d1 : d0;
    end
    erv = '0; erd = '0;
    if (pend_v && !rst) begin
      erv[pend_idx] = 1'b1;
      if (pend_rd) erd = pend_data;
    end
    check_eq("req_ready", 64'(req_ready), 64'(eg));
    check_eq("readEnable", 64'(readEnable), 64'(gi >= 0 && !ewr));
    check_eq("writeEnable", 64'(writeEnable), 64'(gi >= 0 && ewr));
    check_eq("address", 64'(address), 64'(ea));
    if (gi < 0 || ewr) check_eq("writeData", 64'(writeData), 64'(ed));
    check_eq("resp_valid", 64'(resp_valid), 64'(erv));
    check_eq("resp_rdata", 64'(resp_rdata), 64'(erd));
    obs_ready  = req_ready;
    obs_rvalid = resp_valid;
    obs_rdata  = resp_rdata;
    obs_re     = readEnable;
    obs_we     = writeEnable;
    if (rst) begin
      ref_ptr = 0;
      pend_v  = 1'b0;
    end else begin
      pend_v = (gi >= 0);
      if (gi >= 0) begin
        pend_idx  = TB_PTR_W'(gi);
        pend_rd   = !ewr;
        pend_data = ref_mem[ea];
        if (ewr) ref_mem[ea] = ed;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
        ref_ptr = (gi + 1) % NUM_REQ;
`endif
      end
    end
    @(posedge clock);
    #1;
  endtask

  logic [1:0] grants [4];

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      bram[i]    = '0;
      ref_mem[i] = '0;
    end
    readData  = '0;
    reset     = 1'b1;
    scan      = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    @(posedge clock);
    #1;

    // Reset state with requests pending
    run_cycle(1'b1, 2'b11, 2'b01, 8'd3, 8'd4, 32'h1, 32'h2);
    check_eq("rst_ready", 64'(obs_ready), 64'(0));
    check_eq("rst_we", 64'(obs_we), 64'(0));
    run_cycle(1'b1, 2'b11, 2'b00, 8'd3, 8'd4, 32'h1, 32'h2);

    // Idle
    run_cycle(1'b0, 2'b00, 2'b11, 8'd9, 8'd9, 32'h5, 32'h6);
    check_eq("idle_re", 64'(obs_re), 64'(0));
    check_eq("idle_we", 64'(obs_we), 64'(0));
    check_eq("idle_ready", 64'(obs_ready), 64'(0));
    check_eq("idle_rvalid", 64'(obs_rvalid), 64'(0));

    // Write then read through requester 0
    run_cycle(1'b0, 2'b01, 2'b01, 8'd5, 8'd0, 32'hA5, 32'h0);
    run_cycle(1'b0, 2'b01, 2'b00, 8'd5, 8'd0, 32'h0, 32'h0);
    check_eq("wr_resp", 64'(obs_rvalid), 64'(2'b01));
    run_cycle(1'b0, 2'b00, 2'b00, 8'd0, 8'd0, 32'h0, 32'h0);
    check_eq("rd_resp", 64'(obs_rvalid), 64'(2'b01));
    check_eq("rd_data", 64'(obs_rdata), 64'(32'hA5));

    // Back-to-back: requester 1 writes, requester 0 reads the same word next cycle
    run_cycle(1'b0, 2'b10, 2'b10, 8'd0, 8'd1, 32'h0, 32'd11);
    run_cycle(1'b0, 2'b01, 2'b00, 8'd1, 8'd0, 32'h0, 32'h0);
    check_eq("pipe_wresp", 64'(obs_rvalid), 64'(2'b10));
    run_cycle(1'b0, 2'b00, 2'b00, 8'd0, 8'd0, 32'h0, 32'h0);
    check_eq("pipe_rvalid", 64'(obs_rvalid), 64'(2'b01));
    check_eq("pipe_rdata", 64'(obs_rdata), 64'(32'd11));

    // Contention from a fresh pointer
    run_cycle(1'b1, 2'b00, 2'b00, 8'd0, 8'd0, 32'h0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      run_cycle(1'b0, 2'b11, 2'b00, 8'(c), 8'(c + 8), 32'h0, 32'h0);
      grants[c] = obs_ready;
    end
`ifdef BRAM_ARB_ROUND_ROBIN_EN
    check_eq("rr_g0", 64'(grants[0]), 64'(2'b01));
    check_eq("rr_g1", 64'(grants[1]), 64'(2'b10));
    check_eq("rr_g2", 64'(grants[2]), 64'(2'b01));
    check_eq("rr_g3", 64'(grants[3]), 64'(2'b10));
`else
    check_eq("fp_g0", 64'(grants[0]), 64'(2'b01));
    check_eq("fp_g1", 64'(grants[1]), 64'(2'b01));
    check_eq("fp_g2", 64'(grants[2]), 64'(2'b01));
`endif
    run_cycle(1'b0, 2'b00, 2'b00, 8'd0, 8'd0, 32'h0, 32'h0);

    // Reset right after a read grant cancels its response and clears the pointer
    run_cycle(1'b0, 2'b01, 2'b00, 8'd5, 8'd0, 32'h0, 32'h0);
    run_cycle(1'b1, 2'b01, 2'b00, 8'd5, 8'd0, 32'h0, 32'h0);
    check_eq("mrst_rvalid", 64'(obs_rvalid), 64'(0));
    check_eq("mrst_rdata", 64'(obs_rdata), 64'(0));
    check_eq("mrst_ready", 64'(obs_ready), 64'(0));
    check_eq("mrst_re", 64'(obs_re), 64'(0));
    run_cycle(1'b0, 2'b00, 2'b00, 8'd0, 8'd0, 32'h0, 32'h0);
    check_eq("mrst_nopulse", 64'(obs_rvalid), 64'(0));
    run_cycle(1'b0, 2'b11, 2'b00, 8'd5, 8'd6, 32'h0, 32'h0);
    check_eq("mrst_ptr0", 64'(obs_ready), 64'(2'b01));

    // Random traffic over a small address window to exercise read-after-write
    scan = 1'b0;
    for (int n = 0; n < 400; n++) begin
      run_cycle(($urandom % 50) == 0, 2'($urandom), 2'($urandom),
                8'($urandom % 16), 8'($urandom % 16), 32'($urandom), 32'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
